// File: rtl/vga_sink_monitor.sv
// vga_sink_monitor
//   Samples the VGA driver pins on the pixel clock and decodes them back into
//   a pixel stream. It locks to VS, measures every BLANK_N run as a line,
//   counts lines per frame and folds every active pixel into a rotating
//   24-bit checksum. The frame summary is published on each VS start.
// Ports
//   CLOCK_25, reset_n         pixel clock, async active-low reset
//   VGA_HS/VS/BLANK_N/R/G/B   driver pins
//   px_valid/x/y/r/g/b        decoded pixel (two cycles behind the driver)
//   frame_done                one-cycle pulse, summary outputs updated
//   frame_lines/frame_cksum   last frame's line count and checksum
//   h_err/v_err               last frame's geometry errors
//   locked                    previous frame was error-free
module vga_sink_monitor #(
  parameter int   H_ACTIVE = 640,
  parameter int   V_ACTIVE = 480,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        CLOCK_25,
  input  logic        reset_n,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic [7:0]  px_r,
  output logic [7:0]  px_g,
  output logic [7:0]  px_b,
  output logic        frame_done,
  output logic [9:0]  frame_lines,
  output logic [23:0] frame_cksum,
  output logic        h_err,
  output logic        v_err,
  output logic        locked
);
  typedef enum logic [1:0] {UNSYNC, SYNC, LOCK} state_t;

  state_t      state_q, state_d;
  logic        hs_q, vs_q, blank_q, vs_p_q, blank_p_q, hs_seen_q;
  logic        hs_d, vs_d, blank_d, vs_p_d, blank_p_d, hs_seen_d;
  logic [23:0] rgb_q, rgb_d, cksum_q, cksum_d, frame_cksum_q, frame_cksum_d;
  logic [9:0]  x_q, x_d, lines_q, lines_d, frame_lines_q, frame_lines_d;
  logic [10:0] run_q, run_d;
  logic [8:0]  y_q, y_d;
  logic        herr_acc_q, herr_acc_d;
  logic        px_valid_q, px_valid_d, frame_done_q, frame_done_d;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;
  logic [9:0]  px_x_q, px_x_d;
  logic [8:0]  px_y_q, px_y_d;
  logic [23:0] px_rgb_q, px_rgb_d;

  logic        vs_start, line_close, line_start, line_bad, in_sync, sync_ok;
  logic        herr_end, verr_end;
  logic [9:0]  lines_end, cur_x;
  logic [10:0] cur_run;
  logic [23:0] ck_base;

  always_comb begin
    // stage 1 sample and its one-cycle-old copy for edge detection
    hs_d      = VGA_HS;
    vs_d      = VGA_VS;
    blank_d   = VGA_BLANK_N;
    rgb_d     = {VGA_R, VGA_G, VGA_B};
    vs_p_d    = vs_q;
    blank_p_d = blank_q;
    hs_seen_d = hs_seen_q | (hs_q == HS_POL);

    vs_start  = (vs_q == VS_POL) && (vs_p_q != VS_POL);
    in_sync   = (state_q != UNSYNC);
    // no VS lock until the driver has shown at least one HS pulse
    sync_ok   = hs_seen_q | (hs_q == HS_POL);

    // a VS start splits an open run: the part so far closes into the ending
    // frame, a still-high BLANK_N opens a fresh run in the new frame
    line_close = blank_p_q && (!blank_q || vs_start);
    line_start = blank_q && (!blank_p_q || vs_start);
    line_bad   = (run_q != 11'(H_ACTIVE));

    lines_end = (line_close && lines_q != 10'h3ff) ? lines_q + 10'd1 : lines_q;
    herr_end  = herr_acc_q | (line_close & line_bad);
    verr_end  = (lines_end != 10'(V_ACTIVE));

    cur_x   = line_start ? 10'd0 : x_q;
    cur_run = line_start ? 11'd0 : run_q;
    x_d     = x_q;
    run_d   = run_q;
    if (blank_q) begin
      x_d   = (cur_x == 10'h3ff) ? cur_x : cur_x + 10'd1;
      run_d = (cur_run == 11'h7ff) ? cur_run : cur_run + 11'd1;
    end

    y_d = y_q;
    if (vs_start)                       y_d = 9'd0;
    else if (line_close && y_q != 9'h1ff) y_d = y_q + 9'd1;
    lines_d    = vs_start ? 10'd0 : lines_end;
    herr_acc_d = vs_start ? 1'b0 : herr_end;

    ck_base = vs_start ? 24'd0 : cksum_q;
    cksum_d = ck_base;
    if (blank_q && (in_sync || vs_start))
      cksum_d = {ck_base[22:0], ck_base[23]} ^ rgb_q;

    frame_done_d  = 1'b0;
    frame_lines_d = frame_lines_q;
    frame_cksum_d = frame_cksum_q;
    h_err_d       = h_err_q;
    v_err_d       = v_err_q;
    if (vs_start && in_sync) begin
      frame_done_d  = 1'b1;
      frame_lines_d = lines_end;
      frame_cksum_d = cksum_q;
      h_err_d       = herr_end;
      v_err_d       = verr_end;
    end

    state_d = state_q;
    if (vs_start) begin
      case (state_q)
        UNSYNC:  if (sync_ok) state_d = SYNC;
        SYNC:    if (!herr_end && !verr_end) state_d = LOCK;
        LOCK:    if (herr_end || verr_end) state_d = SYNC;
        default: state_d = UNSYNC;
      endcase
    end

    px_valid_d = (state_q == LOCK) & blank_q;
    px_x_d     = cur_x;
    px_y_d     = vs_start ? 9'd0 : y_q;
    px_rgb_d   = rgb_q;
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNSYNC;
      hs_q <= ~HS_POL; vs_q <= ~VS_POL; blank_q <= 1'b0; rgb_q <= '0;
      vs_p_q <= ~VS_POL; blank_p_q <= 1'b0; hs_seen_q <= 1'b0;
      x_q <= '0; run_q <= '0; y_q <= '0; lines_q <= '0; herr_acc_q <= 1'b0;
      cksum_q <= '0;
      frame_done_q <= 1'b0; frame_lines_q <= '0; frame_cksum_q <= '0;
      h_err_q <= 1'b0; v_err_q <= 1'b0;
      px_valid_q <= 1'b0; px_x_q <= '0; px_y_q <= '0; px_rgb_q <= '0;
    end else begin
      state_q <= state_d;
      hs_q <= hs_d; vs_q <= vs_d; blank_q <= blank_d; rgb_q <= rgb_d;
      vs_p_q <= vs_p_d; blank_p_q <= blank_p_d; hs_seen_q <= hs_seen_d;
      x_q <= x_d; run_q <= run_d; y_q <= y_d; lines_q <= lines_d;
      herr_acc_q <= herr_acc_d;
      cksum_q <= cksum_d;
      frame_done_q <= frame_done_d; frame_lines_q <= frame_lines_d;
      frame_cksum_q <= frame_cksum_d;
      h_err_q <= h_err_d; v_err_q <= v_err_d;
      px_valid_q <= px_valid_d; px_x_q <= px_x_d; px_y_q <= px_y_d;
      px_rgb_q <= px_rgb_d;
    end
  end

  assign px_valid    = px_valid_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_r        = px_rgb_q[23:16];
  assign px_g        = px_rgb_q[15:8];
  assign px_b        = px_rgb_q[7:0];
  assign frame_done  = frame_done_q;
  assign frame_lines = frame_lines_q;
  assign frame_cksum = frame_cksum_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign locked      = (state_q == LOCK);
endmodule
